anneal_run_ctrl: RTL and testbench
==================================

Name: anneal_run_ctrl

Overview:
- Host-side sequencer for the neuron-array top (top_neurons).
- Resets the array, writes the active-neuron count and the BEGIN_WR marker, then streams per-neuron configuration words.
- Runs the array for a programmed number of cycles, then raises rd and forwards the packed probe-state readout words to the host.
- Repeats run/read for a programmed number of epochs.

Parameters:
- FP_DATA_WIDTH, 16, width of array ins/outs bus and cfg/res words
- NEURON_ID_WIDTH, 8, width of active-neuron count
- WORDS_PER_NEURON, 4, config words consumed per neuron (Vmem, mu, neuronI, Q)
- RUN_LEN_WIDTH, 16, width of run-length counter
- EPOCH_WIDTH, 8, width of epoch counter
- RD_TIMEOUT, 64, max cycles in READ waiting for arr_read_done

Ports:
- clk  in  1  single clock, shared with the array
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_active_n  in  NEURON_ID_WIDTH  neuron count N, legal 1..2^NEURON_ID_WIDTH-1
- cfg_run_len  in  RUN_LEN_WIDTH  rd-low cycles per epoch
- cfg_epochs  in  EPOCH_WIDTH  number of run/read epochs
- cfg_data  in  FP_DATA_WIDTH  configuration word stream
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  controller accepts cfg_data this cycle
- arr_reset_l  out  1  active-low reset to the array
- arr_ins  out  FP_DATA_WIDTH  drives array ins
- arr_rd  out  1  drives array rd
- arr_outs  in  FP_DATA_WIDTH  array outs (probe-state word)
- arr_read_done  in  1  array readDone
- res_data  out  FP_DATA_WIDTH  readout word
- res_valid  out  1  res_data valid; no backpressure
- res_last  out  1  last readout word of an epoch
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the final epoch
- err  out  2  sticky: bit0 = cfg underrun, bit1 = read timeout; cleared on accepted start

Behaviour:
- All outputs registered.
- Reset values:
  - arr_reset_l=0, arr_ins=0, arr_rd=0, cfg_ready=0
  - res_valid=0, res_last=0, res_data=0
  - busy=0, done=0, err=0
  - state=IDLE
- reset high at any time forces IDLE next cycle and arr_reset_l=0 while reset is high.
- States:
  - IDLE:
    - arr_reset_l=1, outputs otherwise quiet.
    - start with cfg_active_n!=0: latch N, run_len=max(cfg_run_len,1), epochs=max(cfg_epochs,1); clear err; go ARST.
    - start with cfg_active_n==0: ignored; stay IDLE.
  - ARST: arr_reset_l=0 for exactly 2 cycles, then HDR_N.
  - HDR_N: arr_ins={0,N} for 1 cycle, then HDR_GO.
  - HDR_GO: arr_ins=16'hFFFF (BEGIN_WR) for 1 cycle, then LOAD.
  - LOAD:
    - cfg_ready=1; arr_ins=cfg_data when cfg_valid, else 0 with err[0] set.
    - Word counter advances every cycle regardless of cfg_valid, because the array cannot stall.
    - After N*WORDS_PER_NEURON cycles, go RUN.
    - cfg_ready=0 in every other state.
  - RUN: arr_rd=0; count run_len cycles, then READ.
  - READ:
    - arr_rd=1.
    - Starting the cycle after entry, every cycle with arr_rd high: res_valid=1, res_data=arr_outs.
    - On arr_read_done: that cycle's word carries res_last=1; arr_rd=0 next cycle; epochs decrements.
    - If epochs>0, go RUN. Else go DONE.
    - If arr_read_done is not seen within RD_TIMEOUT cycles: set err[1], go IDLE.
  - DONE: done=1 for 1 cycle, then IDLE.
- start outside IDLE is ignored.
- Counters saturate/wrap only within their legal ranges; N*WORDS_PER_NEURON is computed at NEURON_ID_WIDTH+3 bits, so no overflow.

Decomposition:
- Package anneal_ctrl_pkg holds:
  - state enum: IDLE, ARST, HDR_N, HDR_GO, LOAD, RUN, READ, DONE
  - BEGIN_WR constant (all ones)
  - err bit indices
  - ARST_CYCLES=2
- Single module, no sub-module; FSM plus three counters (load, run, epoch) and the timeout counter.

Test Plan:
- Reset, then start with N=4, run_len=10, epochs=1, cfg_valid always high → arr_reset_l low 2 cycles; arr_ins=0x0004 then 0xFFFF; 16 LOAD cycles forwarding data; 10 RUN cycles; READ; done pulse; err=0.
- Same run with cfg_valid dropped on LOAD word 5 → arr_ins=0 on that cycle; err[0]=1; load still ends after 16 cycles.
- epochs=3 with stub array pulsing readDone 3 cycles after rd → three res_last pulses, run gap=run_len each, one done pulse at end.
- Stub never asserts readDone → err[1] set after 64 READ cycles; state IDLE; arr_rd=0.
- cfg_active_n=0 start → no busy; cfg_run_len=0 → exactly 1 RUN cycle.
- reset asserted mid-LOAD → next cycle IDLE, cfg_ready=0, busy=0; a new start replays the full header.

Source files
------------

// File: rtl/anneal_ctrl_pkg.sv
// Shared types and constants for the anneal run controller.
package anneal_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARST,
    HDR_N,
    HDR_GO,
    LOAD,
    RUN,
    READ,
    DONE
  } state_e;

  // BEGIN_WR marker is all ones; sliced down to the array bus width.
  localparam logic [63:0] BEGIN_WR = '1;

  // Sticky error flag bit positions.
  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_TIMEOUT  = 1;

  // Number of cycles the array is held in reset before the header.
  localparam int ARST_CYCLES = 2;

endpackage

// File: rtl/anneal_run_ctrl.sv
// Host-side sequencer for the neuron array: reset, header, config stream,
// then repeated run/read epochs with readout forwarded to the host.
//
// Timing notes:
//  - cfg_ready, busy, done and arr_rd are registered from the next state, so
//    they line up with the cycles the controller spends in LOAD/READ/etc.
//  - arr_reset_l and arr_ins are registered from the current state, so the
//    array sees reset, N, BEGIN_WR and the config words as one gap-free
//    stream; each config word reaches arr_ins the cycle after it is accepted.
//  - res_* follow arr_rd by one cycle: each word sampled while arr_rd is high
//    is presented on the next cycle.
module anneal_run_ctrl
  import anneal_ctrl_pkg::*;
#(
  parameter int FP_DATA_WIDTH    = 16,
  parameter int NEURON_ID_WIDTH  = 8,
  parameter int WORDS_PER_NEURON = 4,
  parameter int RUN_LEN_WIDTH    = 16,
  parameter int EPOCH_WIDTH      = 8,
  parameter int RD_TIMEOUT       = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NEURON_ID_WIDTH-1:0] cfg_active_n,
  input  logic [RUN_LEN_WIDTH-1:0]   cfg_run_len,
  input  logic [EPOCH_WIDTH-1:0]     cfg_epochs,
  input  logic [FP_DATA_WIDTH-1:0]   cfg_data,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic                       arr_reset_l,
  output logic [FP_DATA_WIDTH-1:0]   arr_ins,
  output logic                       arr_rd,
  input  logic [FP_DATA_WIDTH-1:0]   arr_outs,
  input  logic                       arr_read_done,
  output logic [FP_DATA_WIDTH-1:0]   res_data,
  output logic                       res_valid,
  output logic                       res_last,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err
);

  localparam int LOAD_W = NEURON_ID_WIDTH + 3;
  localparam int TMO_W  = $clog2(RD_TIMEOUT) + 1;

  state_e                     state_q, state_d;
  logic [NEURON_ID_WIDTH-1:0] n_q, n_d;
  logic [RUN_LEN_WIDTH-1:0]   run_len_q, run_len_d;
  logic [EPOCH_WIDTH-1:0]     epochs_q, epochs_d;
  logic [1:0]                 arst_cnt_q, arst_cnt_d;
  logic [LOAD_W-1:0]          load_cnt_q, load_cnt_d;
  logic [RUN_LEN_WIDTH-1:0]   run_cnt_q, run_cnt_d;
  logic [TMO_W-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic [LOAD_W-1:0]          load_total;
  logic                       accept_start;
  logic                       rd_timeout;

  logic                       cfg_ready_q, cfg_ready_d;
  logic                       arr_reset_l_q, arr_reset_l_d;
  logic [FP_DATA_WIDTH-1:0]   arr_ins_q, arr_ins_d;
  logic                       arr_rd_q, arr_rd_d;
  logic [FP_DATA_WIDTH-1:0]   res_data_q, res_data_d;
  logic                       res_valid_q, res_valid_d;
  logic                       res_last_q, res_last_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [1:0]                 err_q, err_d;

  assign load_total = LOAD_W'(n_q) * LOAD_W'(WORDS_PER_NEURON);

  // Sequencing: next state, latched job parameters and epoch countdown.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    run_len_d    = run_len_q;
    epochs_d     = epochs_q;
    accept_start = 1'b0;
    rd_timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (cfg_active_n != '0)) begin
          accept_start = 1'b1;
          n_d          = cfg_active_n;
          run_len_d    = (cfg_run_len == '0) ? RUN_LEN_WIDTH'(1) : cfg_run_len;
          epochs_d     = (cfg_epochs == '0) ? EPOCH_WIDTH'(1) : cfg_epochs;
          state_d      = ARST;
        end
      end
      ARST: begin
        if (arst_cnt_q == 2'(ARST_CYCLES - 1)) state_d = HDR_N;
      end
      HDR_N:  state_d = HDR_GO;
      HDR_GO: state_d = LOAD;
      LOAD: begin
        // The array cannot stall, so the count ignores cfg_valid.
        if (load_cnt_q == load_total - LOAD_W'(1)) state_d = RUN;
      end
      RUN: begin
        if (run_cnt_q == run_len_q - RUN_LEN_WIDTH'(1)) state_d = READ;
      end
      READ: begin
        if (arr_read_done) begin
          epochs_d = epochs_q - EPOCH_WIDTH'(1);
          state_d  = (epochs_q == EPOCH_WIDTH'(1)) ? DONE : RUN;
        end else if (tmo_cnt_q == TMO_W'(RD_TIMEOUT - 1)) begin
          rd_timeout = 1'b1;
          state_d    = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state cycle counters; each restarts from zero on entry to its state.
  always_comb begin
    arst_cnt_d = '0;
    load_cnt_d = '0;
    run_cnt_d  = '0;
    tmo_cnt_d  = '0;
    if (state_q == ARST && state_d == ARST) arst_cnt_d = arst_cnt_q + 2'd1;
    if (state_q == LOAD && state_d == LOAD) load_cnt_d = load_cnt_q + LOAD_W'(1);
    if (state_q == RUN  && state_d == RUN)  run_cnt_d  = run_cnt_q + RUN_LEN_WIDTH'(1);
    if (state_q == READ && state_d == READ) tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
  end

  // Output decode for the next cycle, plus sticky error flags.
  always_comb begin
    cfg_ready_d   = (state_d == LOAD);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    arr_rd_d      = (state_d == READ);
    arr_reset_l_d = (state_q != ARST);
    arr_ins_d     = '0;
    unique case (state_q)
      HDR_N:   arr_ins_d = FP_DATA_WIDTH'(n_q);
      HDR_GO:  arr_ins_d = BEGIN_WR[FP_DATA_WIDTH-1:0];
      LOAD:    arr_ins_d = cfg_valid ? cfg_data : '0;
      default: arr_ins_d = '0;
    endcase
    res_valid_d = arr_rd_q;
    res_data_d  = arr_rd_q ? arr_outs : '0;
    res_last_d  = arr_rd_q & arr_read_done;
    err_d       = err_q;
    if (accept_start) err_d = '0;
    if (state_q == LOAD && !cfg_valid) err_d[ERR_UNDERRUN] = 1'b1;
    if (rd_timeout) err_d[ERR_TIMEOUT] = 1'b1;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      n_q           <= '0;
      run_len_q     <= '0;
      epochs_q      <= '0;
      arst_cnt_q    <= '0;
      load_cnt_q    <= '0;
      run_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      cfg_ready_q   <= 1'b0;
      arr_reset_l_q <= 1'b0;
      arr_ins_q     <= '0;
      arr_rd_q      <= 1'b0;
      res_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      run_len_q     <= run_len_d;
      epochs_q      <= epochs_d;
      arst_cnt_q    <= arst_cnt_d;
      load_cnt_q    <= load_cnt_d;
      run_cnt_q     <= run_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      cfg_ready_q   <= cfg_ready_d;
      arr_reset_l_q <= arr_reset_l_d;
      arr_ins_q     <= arr_ins_d;
      arr_rd_q      <= arr_rd_d;
      res_data_q    <= res_data_d;
      res_valid_q   <= res_valid_d;
      res_last_q    <= res_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign arr_reset_l = arr_reset_l_q;
  assign arr_ins     = arr_ins_q;
  assign arr_rd      = arr_rd_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign res_last    = res_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_anneal_run_ctrl.sv
// Scoreboard bench for anneal_run_ctrl: a stub array and a cfg driver feed
// the DUT; jobs push their expected transcript into queues that negedge
// monitors drain.
module tb_anneal_run_ctrl;

  localparam int RD_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_active_n = '0;
  logic [15:0] cfg_run_len = '0;
  logic [7:0]  cfg_epochs = '0;
  logic [15:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        arr_reset_l;
  logic [15:0] arr_ins;
  logic        arr_rd;
  logic [15:0] arr_outs;
  logic        arr_read_done;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_last;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  anneal_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_active_n(cfg_active_n), .cfg_run_len(cfg_run_len), .cfg_epochs(cfg_epochs),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .arr_reset_l(arr_reset_l), .arr_ins(arr_ins), .arr_rd(arr_rd),
    .arr_outs(arr_outs), .arr_read_done(arr_read_done),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected-transcript queues.
  logic [15:0] ins_q[$];
  logic [16:0] res_q[$];
  int          gap_q[$];
  int          arst_q[$];
  logic [1:0]  done_q[$];

  // Knobs shared with the driver and stub.
  int word_idx = 0;
  int drop_idx = -1;
  int rd_delay = 3;
  bit rd_never = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Config source: one fresh word per cycle, valid except on the dropped index.
  initial begin
    logic        v;
    logic [15:0] d;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    forever begin
      @(posedge clk); #1;
      v = (word_idx != drop_idx);
      d = 16'($urandom);
      cfg_valid = v;
      cfg_data  = d;
      if (cfg_ready) begin
        ins_q.push_back(v ? d : 16'h0000);
        word_idx++;
      end
    end
  end

  // Stub array: random probe words; readDone rd_delay cycles after rd rises.
  initial begin
    int rd_cnt;
    rd_cnt = 0;
    arr_outs = '0;
    arr_read_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_cnt = arr_rd ? rd_cnt + 1 : 0;
      arr_outs = 16'($urandom);
      arr_read_done = arr_rd && !rd_never && (rd_cnt == rd_delay + 1);
      if (arr_rd) res_q.push_back({arr_read_done, arr_outs});
    end
  end

  // Array-side monitor: reset pulse length and the header/config stream.
  initial begin
    bit prev_rl;
    bit win;
    int low_len;
    logic [15:0] e;
    prev_rl = 1'b0; win = 1'b0; low_len = 0;
    forever begin
      @(negedge clk);
      if (!arr_reset_l) begin
        low_len++;
        win = 1'b0;
      end else begin
        if (!prev_rl) begin
          if (arst_q.size() > 0) chk("arst_low_cycles", 32'(low_len), 32'(arst_q.pop_front()));
          low_len = 0;
          win = 1'b1;
        end
        if (win) begin
          if (ins_q.size() > 0) begin
            e = ins_q.pop_front();
            chk("arr_ins_word", 32'(arr_ins), 32'(e));
          end else begin
            win = 1'b0;
          end
        end
      end
      prev_rl = arr_reset_l;
    end
  end

  // Host-side monitor: readout words, run gaps and done pulses.
  initial begin
    bit prev_rd;
    bit prev_done;
    int gap;
    logic [16:0] r;
    prev_rd = 1'b0; prev_done = 1'b0; gap = 0;
    forever begin
      @(negedge clk);
      if (res_valid) begin
        if (res_q.size() == 0) begin
          chk("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
          r = res_q.pop_front();
          chk("res_data", 32'(res_data), 32'(r[15:0]));
          chk("res_last", 32'(res_last), 32'(r[16]));
        end
      end
      if (!busy || cfg_ready || arr_rd) begin
        if (arr_rd && !prev_rd) begin
          if (gap_q.size() == 0) chk("rd_unexpected", 32'(arr_rd), 32'd0);
          else chk("run_gap", 32'(gap), 32'(gap_q.pop_front()));
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (done) begin
        chk("done_width", 32'(prev_done), 32'd0);
        if (done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
        else chk("err_at_done", 32'(err), 32'(done_q.pop_front()));
      end
      prev_rd = arr_rd;
      prev_done = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_job(input int n, input int rl, input int ep, input int drop,
                         input int delay, input bit never, input bit stray);
    int rl_eff, ep_eff, cyc, rdh;
    logic [1:0] exp_err;
    rl_eff  = (rl == 0) ? 1 : rl;
    ep_eff  = (ep == 0) ? 1 : ep;
    exp_err = {never, (drop >= 0)};
    arst_q.push_back(2);
    ins_q.push_back(16'(n));
    ins_q.push_back(16'hFFFF);
    if (never) gap_q.push_back(rl_eff);
    else for (int e = 0; e < ep_eff; e++) gap_q.push_back(rl_eff);
    if (!never) done_q.push_back(exp_err);
    word_idx = 0; drop_idx = drop; rd_delay = delay; rd_never = never;
    cfg_active_n = 8'(n); cfg_run_len = 16'(rl); cfg_epochs = 8'(ep);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0; rdh = 0;
    while (busy && cyc < 4000) begin
      if (arr_rd) rdh++;
      if (stray && cyc == 4) begin
        cfg_active_n = 8'(n + 1);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick(1);
      cyc++;
    end
    start = 1'b0;
    chk("idle_reached", 32'(busy), 32'd0);
    chk("rd_high_cycles", 32'(rdh), never ? 32'(RD_TIMEOUT) : 32'(ep_eff * (delay + 1)));
    tick(3);
    chk("ins_q_drained", 32'(ins_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    chk("gap_q_drained", 32'(gap_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    chk("err_idle", 32'(err), 32'(exp_err));
    chk("rd_idle", 32'(arr_rd), 32'd0);
    $display("job n=%0d run_len=%0d epochs=%0d drop=%0d delay=%0d never=%0d err=%0b cycles=%0d",
             n, rl, ep, drop, delay, never, err, cyc);
  endtask

  initial begin
    int n, rl, ep, dr, dl;
    // Reset state.
    reset = 1'b1;
    tick(3);
    chk("rst_arr_reset_l", 32'(arr_reset_l), 32'd0);
    chk("rst_arr_ins", 32'(arr_ins), 32'd0);
    chk("rst_arr_rd", 32'(arr_rd), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_res", 32'({res_valid, res_last, res_data}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick(2);
    chk("idle_arr_reset_l", 32'(arr_reset_l), 32'd1);

    // Directed scenarios.
    run_job(4, 10, 1, -1, 3, 1'b0, 1'b0);
    run_job(4, 10, 1, 5, 3, 1'b0, 1'b0);
    run_job(4, 10, 3, -1, 3, 1'b0, 1'b1);
    run_job(2, 5, 1, -1, 0, 1'b1, 1'b0);
    run_job(2, 0, 2, -1, 1, 1'b0, 1'b0);

    // Zero neuron count is ignored.
    cfg_active_n = 8'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("n0_busy", 32'(busy), 32'd0);
      tick(1);
    end
    $display("start with cfg_active_n=0 ignored, busy=%0b", busy);

    // Reset in the middle of LOAD, then a full replay.
    arst_q.push_back(2);
    ins_q.push_back(16'd4);
    ins_q.push_back(16'hFFFF);
    word_idx = 0; drop_idx = -1;
    cfg_active_n = 8'd4; cfg_run_len = 16'd6; cfg_epochs = 8'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 50 && !cfg_ready; i++) tick(1);
    chk("load_reached", 32'(cfg_ready), 32'd1);
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("midrst_arr_reset_l", 32'(arr_reset_l), 32'd0);
    tick(1);
    reset = 1'b0;
    ins_q.delete(); res_q.delete(); gap_q.delete(); done_q.delete(); arst_q.delete();
    $display("reset asserted mid-LOAD, busy=%0b cfg_ready=%0b", busy, cfg_ready);
    tick(2);
    run_job(4, 6, 1, -1, 2, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      n  = $urandom_range(1, 6);
      rl = $urandom_range(0, 12);
      ep = $urandom_range(0, 3);
      dr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n * 4 - 1) : -1;
      dl = $urandom_range(0, 5);
      run_job(n, rl, ep, dr, dl, 1'b0, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
